// File: rtl/sc_statemachine_point_repeat.sv
// Point/frog movement controller with hold-to-auto-repeat.
// Decodes four active-low direction buttons into one-cycle load/shift strobes
// for the point register bank, honouring the top/bottom/left/right edge
// comparators. A held button repeats its move after DELAY_CYCLES, then every
// REPEAT_CYCLES, while it stays held and unblocked (REPEAT_EN=1).
//
// Ports:
//   SC_STATEMACHINEPOINTREPEAT_CLOCK_50                 system clock
//   SC_STATEMACHINEPOINTREPEAT_RESET_InLow              async reset, active low
//   SC_STATEMACHINEPOINTREPEAT_{up,down,left,right}Button_InLow  buttons, 0 = pressed
//   SC_STATEMACHINEPOINTREPEAT_topsidecomparator_InLow     0 = on top row
//   SC_STATEMACHINEPOINTREPEAT_bottomsidecomparator_InLow  0 = on bottom row
//   SC_STATEMACHINEPOINTREPEAT_sidecomparator_InBus     10 = left edge, 01 = right edge
//   SC_STATEMACHINEPOINTREPEAT_changeP_InBus            01 = clear, 10 = image
//   SC_STATEMACHINEPOINTREPEAT_clear_OutLow             clear strobe
//   SC_STATEMACHINEPOINTREPEAT_changeP_OutLow           image/load-initial strobe
//   SC_STATEMACHINEPOINTREPEAT_load0_OutLow             up-move strobe
//   SC_STATEMACHINEPOINTREPEAT_load1_OutLow             down-move strobe
//   SC_STATEMACHINEPOINTREPEAT_shiftselection_Out       01 left, 10 right, 11 hold
module sc_statemachine_point_repeat #(
  parameter int unsigned DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned CNT_WIDTH     = 25,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic       SC_STATEMACHINEPOINTREPEAT_CLOCK_50,
  input  logic       SC_STATEMACHINEPOINTREPEAT_RESET_InLow,
  input  logic       SC_STATEMACHINEPOINTREPEAT_upButton_InLow,
  input  logic       SC_STATEMACHINEPOINTREPEAT_downButton_InLow,
  input  logic       SC_STATEMACHINEPOINTREPEAT_leftButton_InLow,
  input  logic       SC_STATEMACHINEPOINTREPEAT_rightButton_InLow,
  input  logic       SC_STATEMACHINEPOINTREPEAT_topsidecomparator_InLow,
  input  logic       SC_STATEMACHINEPOINTREPEAT_bottomsidecomparator_InLow,
  input  logic [1:0] SC_STATEMACHINEPOINTREPEAT_sidecomparator_InBus,
  input  logic [1:0] SC_STATEMACHINEPOINTREPEAT_changeP_InBus,
  output logic       SC_STATEMACHINEPOINTREPEAT_clear_OutLow,
  output logic       SC_STATEMACHINEPOINTREPEAT_changeP_OutLow,
  output logic       SC_STATEMACHINEPOINTREPEAT_load0_OutLow,
  output logic       SC_STATEMACHINEPOINTREPEAT_load1_OutLow,
  output logic [1:0] SC_STATEMACHINEPOINTREPEAT_shiftselection_Out
);

  typedef enum logic [3:0] {
    ST_RESET,
    ST_CHECK,
    ST_CLEAR,
    ST_IMAGE,
    ST_UP,
    ST_DOWN,
    ST_LEFT,
    ST_RIGHT,
    ST_HOLD_DELAY,
    ST_HOLD_REPEAT
  } state_e;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  localparam logic [CNT_WIDTH-1:0] DELAY_LIMIT  = CNT_WIDTH'(DELAY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LIMIT = CNT_WIDTH'(REPEAT_CYCLES - 1);

  state_e               state, stateNext;
  dir_e                 dir, dirNext;
  logic [CNT_WIDTH-1:0] holdCnt, holdCntNext;
  logic                 repeatMove, repeatMoveNext;

  logic clearReq, imageReq;
  logic upOk, downOk, leftOk, rightOk;
  logic allReleased;
  logic dirOk;
  state_e dirState;
  logic [CNT_WIDTH-1:0] holdLimit;

  assign clearReq = (SC_STATEMACHINEPOINTREPEAT_changeP_InBus == 2'b01);
  assign imageReq = (SC_STATEMACHINEPOINTREPEAT_changeP_InBus == 2'b10);

  assign upOk    = !SC_STATEMACHINEPOINTREPEAT_upButton_InLow
                   && SC_STATEMACHINEPOINTREPEAT_topsidecomparator_InLow;
  assign downOk  = !SC_STATEMACHINEPOINTREPEAT_downButton_InLow
                   && SC_STATEMACHINEPOINTREPEAT_bottomsidecomparator_InLow;
  assign leftOk  = !SC_STATEMACHINEPOINTREPEAT_leftButton_InLow
                   && (SC_STATEMACHINEPOINTREPEAT_sidecomparator_InBus != 2'b10);
  assign rightOk = !SC_STATEMACHINEPOINTREPEAT_rightButton_InLow
                   && (SC_STATEMACHINEPOINTREPEAT_sidecomparator_InBus != 2'b01);

  assign allReleased = SC_STATEMACHINEPOINTREPEAT_upButton_InLow
                       && SC_STATEMACHINEPOINTREPEAT_downButton_InLow
                       && SC_STATEMACHINEPOINTREPEAT_leftButton_InLow
                       && SC_STATEMACHINEPOINTREPEAT_rightButton_InLow;

  assign holdLimit = (state == ST_HOLD_DELAY) ? DELAY_LIMIT : REPEAT_LIMIT;

  // Legality and target state of the latched direction; only this direction
  // may auto-repeat, whatever other buttons are held alongside it.
  always_comb begin
    dirOk    = 1'b0;
    dirState = ST_UP;
    case (dir)
      DIR_UP:    begin dirOk = upOk;    dirState = ST_UP;    end
      DIR_DOWN:  begin dirOk = downOk;  dirState = ST_DOWN;  end
      DIR_LEFT:  begin dirOk = leftOk;  dirState = ST_LEFT;  end
      DIR_RIGHT: begin dirOk = rightOk; dirState = ST_RIGHT; end
      default:   begin dirOk = 1'b0;    dirState = ST_UP;    end
    endcase
  end

  always_ff @(posedge SC_STATEMACHINEPOINTREPEAT_CLOCK_50
              or negedge SC_STATEMACHINEPOINTREPEAT_RESET_InLow) begin
    if (!SC_STATEMACHINEPOINTREPEAT_RESET_InLow) begin
      state      <= ST_RESET;
      dir        <= DIR_UP;
      holdCnt    <= '0;
      repeatMove <= 1'b0;
    end else begin
      state      <= stateNext;
      dir        <= dirNext;
      holdCnt    <= holdCntNext;
      repeatMove <= repeatMoveNext;
    end
  end

  always_comb begin
    stateNext      = state;
    dirNext        = dir;
    holdCntNext    = holdCnt;
    repeatMoveNext = repeatMove;

    SC_STATEMACHINEPOINTREPEAT_clear_OutLow        = 1'b1;
    SC_STATEMACHINEPOINTREPEAT_changeP_OutLow      = 1'b1;
    SC_STATEMACHINEPOINTREPEAT_load0_OutLow        = 1'b1;
    SC_STATEMACHINEPOINTREPEAT_load1_OutLow        = 1'b1;
    SC_STATEMACHINEPOINTREPEAT_shiftselection_Out  = 2'b11;

    case (state)
      ST_RESET: begin
        SC_STATEMACHINEPOINTREPEAT_changeP_OutLow = 1'b0;
        stateNext = ST_CHECK;
      end

      ST_CHECK: begin
        if (clearReq) begin
          stateNext = ST_CLEAR;
        end else if (imageReq) begin
          stateNext = ST_IMAGE;
        end else if (upOk) begin
          stateNext = ST_UP;    dirNext = DIR_UP;    repeatMoveNext = 1'b0;
        end else if (downOk) begin
          stateNext = ST_DOWN;  dirNext = DIR_DOWN;  repeatMoveNext = 1'b0;
        end else if (leftOk) begin
          stateNext = ST_LEFT;  dirNext = DIR_LEFT;  repeatMoveNext = 1'b0;
        end else if (rightOk) begin
          stateNext = ST_RIGHT; dirNext = DIR_RIGHT; repeatMoveNext = 1'b0;
        end
      end

      ST_UP, ST_DOWN, ST_LEFT, ST_RIGHT: begin
        case (state)
          ST_UP:    SC_STATEMACHINEPOINTREPEAT_load0_OutLow       = 1'b0;
          ST_DOWN:  SC_STATEMACHINEPOINTREPEAT_load1_OutLow       = 1'b0;
          ST_LEFT:  SC_STATEMACHINEPOINTREPEAT_shiftselection_Out = 2'b01;
          default:  SC_STATEMACHINEPOINTREPEAT_shiftselection_Out = 2'b10;
        endcase
        stateNext   = repeatMove ? ST_HOLD_REPEAT : ST_HOLD_DELAY;
        holdCntNext = '0;
      end

      ST_HOLD_DELAY, ST_HOLD_REPEAT: begin
        if (clearReq) begin
          stateNext   = ST_CLEAR;
          holdCntNext = '0;
        end else if (imageReq) begin
          stateNext   = ST_IMAGE;
          holdCntNext = '0;
        end else if (allReleased) begin
          stateNext   = ST_CHECK;
          holdCntNext = '0;
        end else if (holdCnt == holdLimit) begin
          // Counter restarts at the limit either way; a blocked or released
          // dir simply re-arms the same hold phase.
          holdCntNext = '0;
          if (REPEAT_EN && dirOk) begin
            stateNext      = dirState;
            repeatMoveNext = 1'b1;
          end
        end else begin
          holdCntNext = holdCnt + CNT_WIDTH'(1);
        end
      end

      ST_IMAGE: begin
        SC_STATEMACHINEPOINTREPEAT_changeP_OutLow = 1'b0;
        if (!imageReq) stateNext = ST_CLEAR;
      end

      ST_CLEAR: begin
        SC_STATEMACHINEPOINTREPEAT_clear_OutLow = 1'b0;
        stateNext = ST_CHECK;
      end

      default: stateNext = ST_CHECK;
    endcase
  end

endmodule

// File: tb/tb_sc_statemachine_point_repeat.sv
module tb_sc_statemachine_point_repeat;

  localparam int unsigned DLY = 4;
  localparam int unsigned RPT = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
  logic       top = 1'b1, bottom = 1'b1;
  logic [1:0] side = 2'b00, chg = 2'b00;

  logic       aClr, aChg, aL0, aL1;
  logic [1:0] aSh;
  logic       bClr, bChg, bL0, bL1;
  logic [1:0] bSh;
  logic [5:0] outA, outB;

  assign outA = {aClr, aChg, aL0, aL1, aSh};
  assign outB = {bClr, bChg, bL0, bL1, bSh};

  localparam logic [5:0] O_IDLE  = 6'b111111;
  localparam logic [5:0] O_RST   = 6'b101111;
  localparam logic [5:0] O_CLR   = 6'b011111;
  localparam logic [5:0] O_UP    = 6'b110111;
  localparam logic [5:0] O_DOWN  = 6'b111011;
  localparam logic [5:0] O_LEFT  = 6'b111101;
  localparam logic [5:0] O_RIGHT = 6'b111110;

  sc_statemachine_point_repeat #(
    .DELAY_CYCLES(DLY), .REPEAT_CYCLES(RPT), .CNT_WIDTH(3), .REPEAT_EN(1'b1)
  ) dutA (
    .SC_STATEMACHINEPOINTREPEAT_CLOCK_50(clk),
    .SC_STATEMACHINEPOINTREPEAT_RESET_InLow(rst_n),
    .SC_STATEMACHINEPOINTREPEAT_upButton_InLow(up),
    .SC_STATEMACHINEPOINTREPEAT_downButton_InLow(down),
    .SC_STATEMACHINEPOINTREPEAT_leftButton_InLow(left),
    .SC_STATEMACHINEPOINTREPEAT_rightButton_InLow(right),
    .SC_STATEMACHINEPOINTREPEAT_topsidecomparator_InLow(top),
    .SC_STATEMACHINEPOINTREPEAT_bottomsidecomparator_InLow(bottom),
    .SC_STATEMACHINEPOINTREPEAT_sidecomparator_InBus(side),
    .SC_STATEMACHINEPOINTREPEAT_changeP_InBus(chg),
    .SC_STATEMACHINEPOINTREPEAT_clear_OutLow(aClr),
    .SC_STATEMACHINEPOINTREPEAT_changeP_OutLow(aChg),
    .SC_STATEMACHINEPOINTREPEAT_load0_OutLow(aL0),
    .SC_STATEMACHINEPOINTREPEAT_load1_OutLow(aL1),
    .SC_STATEMACHINEPOINTREPEAT_shiftselection_Out(aSh)
  );

  sc_statemachine_point_repeat #(
    .DELAY_CYCLES(DLY), .REPEAT_CYCLES(RPT), .CNT_WIDTH(3), .REPEAT_EN(1'b0)
  ) dutB (
    .SC_STATEMACHINEPOINTREPEAT_CLOCK_50(clk),
    .SC_STATEMACHINEPOINTREPEAT_RESET_InLow(rst_n),
    .SC_STATEMACHINEPOINTREPEAT_upButton_InLow(up),
    .SC_STATEMACHINEPOINTREPEAT_downButton_InLow(down),
    .SC_STATEMACHINEPOINTREPEAT_leftButton_InLow(left),
    .SC_STATEMACHINEPOINTREPEAT_rightButton_InLow(right),
    .SC_STATEMACHINEPOINTREPEAT_topsidecomparator_InLow(top),
    .SC_STATEMACHINEPOINTREPEAT_bottomsidecomparator_InLow(bottom),
    .SC_STATEMACHINEPOINTREPEAT_sidecomparator_InBus(side),
    .SC_STATEMACHINEPOINTREPEAT_changeP_InBus(chg),
    .SC_STATEMACHINEPOINTREPEAT_clear_OutLow(bClr),
    .SC_STATEMACHINEPOINTREPEAT_changeP_OutLow(bChg),
    .SC_STATEMACHINEPOINTREPEAT_load0_OutLow(bL0),
    .SC_STATEMACHINEPOINTREPEAT_load1_OutLow(bL1),
    .SC_STATEMACHINEPOINTREPEAT_shiftselection_Out(bSh)
  );

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;

  task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int exp);
    nAssert++;
    if (got != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timing is tracked as absolute cycle numbers: after a strobe in cycle s the
  // next repeat is due in cycle s+gap+1; a due cycle that finds the direction
  // blocked pushes the next due cycle out by gap.
  typedef enum {M_RST, M_IDLE, M_CLR, M_IMG, M_MOVE, M_WAIT} mmode_e;

  mmode_e mMode[2] = '{M_RST, M_RST};
  int     mDir[2]  = '{0, 0};
  bit     mFirst[2];
  int     mGap[2];
  int     mDue[2];
  int     mCyc[2];
  bit     mEn[2] = '{1'b1, 1'b0};

  function automatic bit legal(input int d);
    case (d)
      0:       return !up && top;
      1:       return !down && bottom;
      2:       return !left && (side != 2'b10);
      default: return !right && (side != 2'b01);
    endcase
  endfunction

  function automatic logic [5:0] expOut(input int i);
    case (mMode[i])
      M_RST, M_IMG: return O_RST;
      M_CLR:        return O_CLR;
      M_MOVE: case (mDir[i])
                0:       return O_UP;
                1:       return O_DOWN;
                2:       return O_LEFT;
                default: return O_RIGHT;
              endcase
      default:      return O_IDLE;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mMode[i] = M_RST;
        mDir[i]  = 0;
        mCyc[i]  = 0;
      end else begin
        mCyc[i]++;
        case (mMode[i])
          M_RST, M_CLR: mMode[i] = M_IDLE;
          M_IMG: mMode[i] = (chg == 2'b10) ? M_IMG : M_CLR;
          M_MOVE: begin
            mGap[i]  = mFirst[i] ? int'(DLY) : int'(RPT);
            mDue[i]  = mCyc[i] + mGap[i];
            mMode[i] = M_WAIT;
          end
          M_WAIT: begin
            if (chg == 2'b01) mMode[i] = M_CLR;
            else if (chg == 2'b10) mMode[i] = M_IMG;
            else if (up && down && left && right) mMode[i] = M_IDLE;
            else if (mCyc[i] == mDue[i]) begin
              if (mEn[i] && legal(mDir[i])) begin
                mMode[i]  = M_MOVE;
                mFirst[i] = 1'b0;
              end else begin
                mDue[i] += mGap[i];
              end
            end
          end
          default: begin
            if (chg == 2'b01) mMode[i] = M_CLR;
            else if (chg == 2'b10) mMode[i] = M_IMG;
            else begin
              for (int d = 3; d >= 0; d--) begin
                if (legal(d)) begin
                  mMode[i]  = M_MOVE;
                  mDir[i]   = d;
                  mFirst[i] = 1'b1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    check6("modelA", outA, expOut(0));
    check6("modelB", outB, expOut(1));
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] maskA, maskB, expMaskA, expMaskB;
    int cntA, cntB, cntC;

    // Reset and release
    repeat (2) @(negedge clk);
    check6("rst_held", outA, O_RST);
    #2 rst_n = 1'b1;
    #1 check6("rst_release", outA, O_RST);
    @(negedge clk) check6("idle_after_rst", outA, O_IDLE);
    @(negedge clk) check6("idle_after_rst2", outA, O_IDLE);

    // Hold right for 20 cycles
    expMaskA = 32'h0;
    expMaskA[1] = 1'b1; expMaskA[6] = 1'b1; expMaskA[9] = 1'b1;
    expMaskA[12] = 1'b1; expMaskA[15] = 1'b1; expMaskA[18] = 1'b1;
    expMaskB = 32'h0;
    expMaskB[1] = 1'b1;
    maskA = '0;
    maskB = '0;
    right = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (aSh == 2'b10) maskA[n] = 1'b1;
      if (bSh == 2'b10) maskB[n] = 1'b1;
    end
    right = 1'b1;
    checkInt("right_repeat_mask", int'(maskA), int'(expMaskA));
    checkInt("right_norepeat_mask", int'(maskB), int'(expMaskB));
    cntA = 0;
    repeat (10) begin @(negedge clk); if (aSh != 2'b11) cntA++; end
    checkInt("no_shift_after_release", cntA, 0);

    // Up blocked at top row
    top = 1'b0; up = 1'b0;
    cntA = 0;
    repeat (10) begin @(negedge clk); if (!aL0) cntA++; end
    checkInt("up_blocked", cntA, 0);

    // Up (blocked) plus left: single left shift
    left = 1'b0;
    cntA = 0; cntB = 0;
    repeat (3) begin @(negedge clk); if (aSh == 2'b01) cntA++; if (!aL0) cntB++; end
    checkInt("left_fallthrough", cntA, 1);
    checkInt("left_fallthrough_no_up", cntB, 0);
    up = 1'b1; left = 1'b1;
    repeat (2) @(negedge clk);
    top = 1'b1;

    // REPEAT_EN = 0: long down hold gives one pulse
    down = 1'b0;
    cntB = 0;
    repeat (50) begin @(negedge clk); if (!bL1) cntB++; end
    checkInt("norepeat_single_down", cntB, 1);
    down = 1'b1;
    repeat (3) @(negedge clk);

    // Image request during a hold
    right = 1'b0;
    repeat (3) @(negedge clk);
    chg = 2'b10; right = 1'b1;
    @(negedge clk) check6("image_1", outA, O_RST);
    @(negedge clk) check6("image_2", outA, O_RST);
    @(negedge clk) check6("image_3", outA, O_RST);
    chg = 2'b00;
    @(negedge clk) check6("clear_after_image", outA, O_CLR);
    @(negedge clk) check6("check_after_clear", outA, O_IDLE);
    repeat (2) @(negedge clk);

    // Right edge reached during repeat
    right = 1'b0;
    repeat (10) @(negedge clk);
    side = 2'b01;
    cntA = 0;
    repeat (10) begin @(negedge clk); if (aSh != 2'b11) cntA++; end
    checkInt("edge_stops_repeat", cntA, 0);
    right = 1'b1;
    repeat (2) @(negedge clk);
    left = 1'b0;
    @(negedge clk) check6("left_after_edge", outA, O_LEFT);
    left = 1'b1;
    repeat (3) @(negedge clk);
    side = 2'b00;

    // Asynchronous reset during HOLD_REPEAT
    down = 1'b0;
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check6("async_rst_A", outA, O_RST);
    check6("async_rst_B", outB, O_RST);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check6("rst_release2", outA, O_RST);
    @(negedge clk) check6("check_before_fresh", outA, O_IDLE);
    @(negedge clk) check6("fresh_down", outA, O_DOWN);
    down = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 100000);
    $fatal(1, "timeout");
  end

endmodule
